// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: pops burst_len words from fifo16 and streams them out over valid/ready.
// Ports: clk; rst (sync, active-low); start/burst_len burst request (sampled in IDLE);
// buf_empty/buf_out FIFO read side with one-cycle read latency; rd_en FIFO pop strobe;
// data_out/valid_out/ready_in output stream; busy high outside IDLE; done one-cycle
// completion pulse; pop_count cumulative pops, live only with FIFO_POP_CTRL_STATS_EN.
module fifo_pop_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int BUF_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BUF_WIDTH:0]    burst_len,
  input  logic                  buf_empty,
  input  logic [DATA_WIDTH-1:0] buf_out,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  done,
  output logic [BUF_WIDTH:0]    pop_count
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
  localparam logic [BUF_WIDTH:0] ONE = {{BUF_WIDTH{1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [BUF_WIDTH:0] remaining_q, remaining_d, pending_q, pending_d;
  logic [1:0] occ_q, occ_d;
  logic rd_q;
  logic [DATA_WIDTH-1:0] data_q, data_d, skid_q, skid_d;
  logic accept, out_free;
  assign valid_out = occ_q != 2'd0;
  assign data_out = data_q;
  assign accept = valid_out && ready_in;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  // the output register can take the returning word if it is empty or emptying this edge
  assign out_free = occ_q == 2'd0 || (occ_q == 2'd1 && accept);
  // words held plus the one in flight, after this cycle's accept, must leave room
  assign rd_en = state_q == READ && remaining_q != '0 && !buf_empty &&
                 ({1'b0, occ_q} + {2'b0, rd_q} - {2'b0, accept}) < 3'd2;
  always_comb begin
    state_d = state_q;
    remaining_d = rd_en ? remaining_q - ONE : remaining_q;
    pending_d = accept ? pending_q - ONE : pending_q;
    occ_d = occ_q + {1'b0, rd_q} - {1'b0, accept};
    data_d = (accept && occ_q == 2'd2) ? skid_q : data_q;
    skid_d = (rd_q && !out_free) ? buf_out : skid_q;
    if (rd_q && out_free) data_d = buf_out;
    case (state_q)
      IDLE: if (start) begin
        state_d = burst_len == '0 ? DONE : READ;
        remaining_d = burst_len;
        pending_d = burst_len;
      end
      READ: if (rd_en && remaining_q == ONE) state_d = FLUSH;
      FLUSH: if (accept && pending_q == ONE) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      remaining_q <= '0;
      pending_q <= '0;
      occ_q <= 2'd0;
      rd_q <= 1'b0;
      data_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      remaining_q <= remaining_d;
      pending_q <= pending_d;
      occ_q <= occ_d;
      rd_q <= rd_en;
      data_q <= data_d;
      skid_q <= skid_d;
    end
  end
`ifdef FIFO_POP_CTRL_STATS_EN
  logic [BUF_WIDTH:0] pop_count_q, pop_count_d;
  assign pop_count_d = rd_en ? pop_count_q + ONE : pop_count_q;
  assign pop_count = pop_count_q;
  always_ff @(posedge clk) begin
    if (!rst) pop_count_q <= '0;
    else pop_count_q <= pop_count_d;
  end
`else
  assign pop_count = '0;
`endif
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl: queue-based FIFO environment and stream model checking fifo_pop_ctrl every cycle.
module tb_fifo_pop_ctrl;
  localparam int DW = 4;
  localparam int BW = 4;
  localparam int P_IDLE = 0;
  localparam int P_ACT = 1;
  localparam int P_DONE = 2;
`ifdef FIFO_POP_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic buf_empty = 1'b1;
  logic ready_in = 1'b0;
  logic [BW:0] burst_len = '0;
  logic [DW-1:0] buf_out = '0;
  logic rd_en, valid_out, busy, done;
  logic [DW-1:0] data_out;
  logic [BW:0] pop_count;
  always #5 clk = ~clk;
  fifo_pop_ctrl #(.DATA_WIDTH(DW), .BUF_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .buf_empty(buf_empty), .buf_out(buf_out), .rd_en(rd_en),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy(busy), .done(done), .pop_count(pop_count)
  );
  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int phase = P_IDLE;
  int rem = 0;
  int pend = 0;
  int exp_pc = 0;
  int rds = 0;
  int first_valid = -1;
  int done_cyc = -1;
  int last_acc = -1;
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] avail[$];
  logic [DW-1:0] inflight[$];
  logic [DW-1:0] got[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic step();
    int acc_m;
    int e_rd;
    logic s_rd;
    logic [DW-1:0] w;
    buf_empty = fifo.size() == 0;
    #1;
    acc_m = (avail.size() != 0 && ready_in) ? 1 : 0;
    if (rst) begin
      chk("valid_out", int'(valid_out), int'(avail.size() != 0));
      if (avail.size() != 0) chk("data_out", int'(data_out), int'(avail[0]));
      chk("busy", int'(busy), int'(phase != P_IDLE));
      chk("done", int'(done), int'(phase == P_DONE));
      e_rd = (phase == P_ACT && rem != 0 && fifo.size() != 0 &&
              avail.size() + inflight.size() - acc_m < 2) ? 1 : 0;
      chk("rd_en", int'(rd_en), e_rd);
      chk("pop_count", int'(pop_count), STATS ? exp_pc % 32 : 0);
      if (valid_out && first_valid < 0) first_valid = cyc_n;
      if (valid_out && ready_in) begin
        got.push_back(data_out);
        last_acc = cyc_n;
      end
      if (done) done_cyc = cyc_n;
      if (rd_en) rds++;
    end
    s_rd = rd_en;
    @(posedge clk);
    #1;
    cyc_n++;
    if (!rst) begin
      avail.delete();
      inflight.delete();
      fifo.delete();
      phase = P_IDLE;
      rem = 0;
      pend = 0;
      exp_pc = 0;
    end else begin
      if (acc_m != 0) void'(avail.pop_front());
      if (inflight.size() != 0) avail.push_back(inflight.pop_front());
      if (s_rd && fifo.size() != 0) begin
        w = fifo.pop_front();
        inflight.push_back(w);
        buf_out = w;
      end
      if (s_rd) exp_pc++;
      case (phase)
        P_IDLE: if (start) begin
          if (burst_len == 0) phase = P_DONE;
          else begin
            phase = P_ACT;
            rem = int'(burst_len);
            pend = int'(burst_len);
          end
        end
        P_ACT: begin
          if (s_rd) rem--;
          if (acc_m != 0) pend--;
          if (pend == 0) phase = P_DONE;
        end
        default: phase = P_IDLE;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic clr();
    got.delete();
    rds = 0;
    first_valid = -1;
    done_cyc = -1;
    last_acc = -1;
  endtask

  task automatic go(input int len);
    start = 1'b1;
    burst_len = len[BW:0];
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (done_cyc < 0 && k < max) begin
      step();
      k++;
    end
    chk("done_seen", int'(done_cyc >= 0), 1);
  endtask

  task automatic chk_got(input string name, input int base, input int n);
    chk(name, got.size(), n);
    for (int i = 0; i < n; i++) chk(name, i < got.size() ? int'(got[i]) : -1, base + i);
  endtask

  initial begin
    int sc;
    @(negedge clk);
    step();
    step();
    rst = 1'b1;
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pop_count", int'(pop_count), 0);

    ready_in = 1'b1;
    for (int i = 1; i <= 3; i++) fifo.push_back(i[DW-1:0]);
    clr();
    sc = cyc_n;
    go(3);
    wait_done(20);
    chk_got("basic_word", 1, 3);
    chk("basic_rd_pulses", rds, 3);
    chk("basic_first_latency", first_valid - sc, 3);
    chk("basic_done_after_accept", done_cyc - last_acc, 1);

    for (int i = 10; i <= 14; i++) fifo.push_back(i[DW-1:0]);
    clr();
    go(5);
    for (int k = 0; k < 60 && done_cyc < 0; k++) begin
      ready_in = (k % 3) == 0;
      step();
    end
    chk("bp_done_seen", int'(done_cyc >= 0), 1);
    chk_got("bp_word", 10, 5);
    chk("bp_rd_pulses", rds, 5);

    ready_in = 1'b1;
    clr();
    go(2);
    repeat (4) step();
    chk("starve_rd", rds, 0);
    chk("starve_busy", int'(busy), 1);
    fifo.push_back(4'd7);
    step();
    fifo.push_back(4'd8);
    wait_done(20);
    chk_got("starve_word", 7, 2);

    clr();
    sc = cyc_n;
    go(0);
    wait_done(5);
    chk("zero_done_latency", done_cyc - sc, 1);
    chk("zero_rd", rds, 0);

    for (int i = 1; i <= 4; i++) fifo.push_back(i[DW-1:0]);
    clr();
    go(4);
    start = 1'b1;
    burst_len = 5'd9;
    step();
    start = 1'b0;
    wait_done(20);
    chk("ignored_start_rd", rds, 4);
    chk_got("ignored_start_word", 1, 4);
    repeat (2) step();
    chk("ignored_start_idle", int'(busy), 0);

    for (int i = 1; i <= 6; i++) fifo.push_back(i[DW-1:0]);
    ready_in = 1'b0;
    go(6);
    repeat (4) step();
    chk("prereset_valid", int'(valid_out), 1);
    chk("prereset_busy", int'(busy), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_valid", int'(valid_out), 0);
    chk("midrst_data", int'(data_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rd", int'(rd_en), 0);
    chk("midrst_done", int'(done), 0);
    ready_in = 1'b1;

    for (int i = 0; i < 16; i++) fifo.push_back(i[DW-1:0]);
    clr();
    go(16);
    wait_done(80);
    chk_got("stats_word", 0, 16);
    fifo.push_back(4'd9);
    clr();
    go(1);
    wait_done(20);
    chk("stats_pop_count", int'(pop_count), STATS ? 17 : 0);

    for (int k = 0; k < 600; k++) begin
      ready_in = $urandom_range(0, 3) != 0;
      if (fifo.size() < 16 && $urandom_range(0, 2) == 0) fifo.push_back(DW'($urandom));
      start = $urandom_range(0, 3) == 0;
      burst_len = BW'($urandom_range(0, 8));
      rst = $urandom_range(0, 149) != 0;
      step();
    end
    rst = 1'b1;
    start = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
